shift_issue_stage: RTL and testbench

- Decode/execute boundary register that feeds the 32-bit left barrel shifter in the execute stage.
- Accepts shift micro-ops from decode over a valid/ready handshake and selects the shift amount (immediate or register-sourced).
- Preconditions the operand so the left-only shifter also executes SRL and SRA, then emits operand, shamt and post-processing flags one cycle later.
- Holds up to two ops in a skid buffer, so upstream ready is fully registered.

---
 rtl/shift_pkg.sv | 32 +++
 rtl/shift_precond.sv | 49 ++++
 rtl/shift_issue_stage.sv | 86 ++++++++
 tb/tb_shift_issue_stage.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift issue stage.
// Payload layout is common to both storage registers.
package shift_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;
  localparam int RDW   = 5;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] operand;
    logic [SHW-1:0]   shamt;
    logic             reverse;
    logic             invert;
    logic [RDW-1:0]   rd;
  } payload_t;

  function automatic logic [WIDTH-1:0] bitrev(
    input logic [WIDTH-1:0] v
  );
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_precond.sv
// Maps SLL/SRL/SRA/PASS onto a left-only shifter by
// preconditioning the operand and flagging post-processing.
module shift_precond
  import shift_pkg::*;
(
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   shamt_imm,
  input  logic [WIDTH-1:0] shamt_reg,
  input  logic             use_reg,
  input  logic [RDW-1:0]   rd,
  output payload_t         payload
);

  logic unused_hi;
  assign unused_hi = ^shamt_reg[WIDTH-1:SHW];

  always_comb begin
    payload         = '0;
    payload.rd      = rd;
    payload.operand = operand;
    payload.shamt   = use_reg ? shamt_reg[SHW-1:0]
                              : shamt_imm;
    unique case (op)
      OP_SLL: begin
      end
      OP_SRL: begin
        payload.operand = bitrev(operand);
        payload.reverse = 1'b1;
      end
      OP_SRA: begin
        // Negative: shift in ones by working on ~x.
        if (operand[WIDTH-1]) begin
          payload.operand = bitrev(~operand);
          payload.invert  = 1'b1;
        end else begin
          payload.operand = bitrev(operand);
        end
        payload.reverse = 1'b1;
      end
      OP_PASS: begin
        payload.shamt = '0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Decode/execute boundary for the left barrel shifter.
// Main register plus one skid slot; in_ready is a flop.
module shift_issue_stage #(
  parameter int WIDTH = shift_pkg::WIDTH,
  parameter int SHW   = shift_pkg::SHW,
  parameter int RDW   = shift_pkg::RDW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_operand,
  input  logic [SHW-1:0]   in_shamt_imm,
  input  logic [WIDTH-1:0] in_shamt_reg,
  input  logic             in_use_reg,
  input  logic [RDW-1:0]   in_rd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_operand,
  output logic [SHW-1:0]   out_shamt,
  output logic             out_reverse,
  output logic             out_invert,
  output logic [RDW-1:0]   out_rd
);

  import shift_pkg::payload_t;

  payload_t pl;
  payload_t main_q;
  payload_t skid_q;
  logic     main_v;
  logic     skid_v;
  logic     acc;
  logic     drain;

  shift_precond u_precond (
    .op        (in_op),
    .operand   (in_operand),
    .shamt_imm (in_shamt_imm),
    .shamt_reg (in_shamt_reg),
    .use_reg   (in_use_reg),
    .rd        (in_rd),
    .payload   (pl)
  );

  assign in_ready = ~skid_v;
  assign acc      = in_valid & in_ready & ~flush;
  assign drain    = main_v & out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (drain || !main_v) begin
      // Skid is older than anything arriving now.
      if (skid_v) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else if (acc) begin
        main_q <= pl;
        main_v <= 1'b1;
      end else begin
        main_v <= 1'b0;
      end
    end else if (acc) begin
      skid_q <= pl;
      skid_v <= 1'b1;
    end
  end

  assign out_valid   = main_v;
  assign out_operand = main_q.operand;
  assign out_shamt   = main_q.shamt;
  assign out_reverse = main_q.reverse;
  assign out_invert  = main_q.invert;
  assign out_rd      = main_q.rd;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed self-checking bench for shift_issue_stage.
// Inputs change on negedge; outputs sampled 1ns after posedge.
module tb_shift_issue_stage;

  logic        clock = 0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_operand;
  logic [4:0]  in_shamt_imm;
  logic [31:0] in_shamt_reg;
  logic        in_use_reg;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_operand;
  logic [4:0]  out_shamt;
  logic        out_reverse;
  logic        out_invert;
  logic [4:0]  out_rd;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  shift_issue_stage dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_operand   (in_operand),
    .in_shamt_imm (in_shamt_imm),
    .in_shamt_reg (in_shamt_reg),
    .in_use_reg   (in_use_reg),
    .in_rd        (in_rd),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_operand  (out_operand),
    .out_shamt    (out_shamt),
    .out_reverse  (out_reverse),
    .out_invert   (out_invert),
    .out_rd       (out_rd)
  );

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  task automatic drive(input logic v, input logic [1:0] op,
                       input logic [31:0] opnd,
                       input logic [4:0] imm,
                       input logic [31:0] sreg,
                       input logic ur, input logic [4:0] rd);
    @(negedge clock);
    in_valid     = v;
    in_op        = op;
    in_operand   = opnd;
    in_shamt_imm = imm;
    in_shamt_reg = sreg;
    in_use_reg   = ur;
    in_rd        = rd;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 2'b00, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1; flush = 0; out_ready = 0;
    in_valid = 0; in_op = 0; in_operand = 0;
    in_shamt_imm = 0; in_shamt_reg = 0;
    in_use_reg = 0; in_rd = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b exp 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", in_ready);
    end
    checks++;
    if ({out_operand, out_shamt, out_reverse, out_invert,
         out_rd} !== 44'h0) begin
      errors++;
      $display("FAIL reset_payload got %h exp 0", out_operand);
    end
    // inputs ignored while reset is high
    drive(1, 2'b00, 32'h5, 5'd1, 0, 0, 5'd7);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignore got %b exp 0", out_valid);
    end
    drive(0, 2'b00, 0, 0, 0, 0, 0);
    reset = 0;
    idle(1);
  endtask

  task automatic test_sll();
    out_ready = 1;
    drive(1, 2'b00, 32'h1, 5'd4, 32'hFFFF_FFFF, 0, 5'd3);
    tick();
    checks++;
    if ({out_valid, out_operand, out_shamt, out_reverse,
         out_invert, out_rd} !== {1'b1, 32'h1, 5'd4, 1'b0,
                                  1'b0, 5'd3}) begin
      errors++;
      $display("FAIL sll got v=%b op=%h sh=%0d r=%b i=%b",
               out_valid, out_operand, out_shamt,
               out_reverse, out_invert);
    end
    idle(2);
  endtask

  task automatic test_srl();
    out_ready = 1;
    drive(1, 2'b01, 32'h8000_0000, 5'd31, 0, 0, 5'd4);
    tick();
    checks++;
    if ({out_valid, out_operand, out_shamt, out_reverse,
         out_invert} !== {1'b1, 32'h1, 5'd31, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL srl got op=%h sh=%0d r=%b i=%b",
               out_operand, out_shamt, out_reverse, out_invert);
    end
    // SRA on a non-negative value behaves as SRL
    drive(1, 2'b10, 32'h0000_0100, 5'd2, 0, 0, 5'd5);
    tick();
    checks++;
    if ({out_operand, out_shamt, out_reverse, out_invert}
        !== {32'h0080_0000, 5'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sra_pos got op=%h sh=%0d r=%b i=%b",
               out_operand, out_shamt, out_reverse, out_invert);
    end
    idle(2);
  endtask

  task automatic test_sra_neg();
    logic [31:0] res;
    out_ready = 1;
    drive(1, 2'b10, 32'hF000_0000, 5'd9, 32'h24, 1, 5'd6);
    tick();
    checks++;
    if ({out_operand, out_shamt, out_reverse, out_invert}
        !== {32'hFFFF_FFF0, 5'd4, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sra_neg got op=%h sh=%0d r=%b i=%b",
               out_operand, out_shamt, out_reverse, out_invert);
    end
    res = out_operand << out_shamt;
    if (out_reverse) res = rev32(res);
    if (out_invert) res = ~res;
    checks++;
    if (res !== 32'hFF00_0000) begin
      errors++;
      $display("FAIL sra_post got %h exp ff000000", res);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    drive(1, 2'b00, 32'hA, 5'd1, 0, 0, 5'd1);
    tick();
    drive(1, 2'b00, 32'hB, 5'd2, 0, 0, 5'd2);
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL skid_ready got %b exp 0", in_ready);
    end
    drive(1, 2'b00, 32'hC, 5'd3, 0, 0, 5'd3);
    tick();
    checks++;
    if ({out_valid, out_rd, in_ready} !== {1'b1, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL hold_a got v=%b rd=%0d rdy=%b exp 1 1 0",
               out_valid, out_rd, in_ready);
    end
    @(negedge clock);
    out_ready = 1;
    tick();
    checks++;
    if ({out_valid, out_rd, in_ready} !== {1'b1, 5'd2, 1'b1}) begin
      errors++;
      $display("FAIL order_b got v=%b rd=%0d rdy=%b exp 1 2 1",
               out_valid, out_rd, in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_rd, out_operand} !==
        {1'b1, 5'd3, 32'hC}) begin
      errors++;
      $display("FAIL order_c got v=%b rd=%0d exp 1 3",
               out_valid, out_rd);
    end
    drive(0, 2'b00, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_dup got v=%b rd=%0d exp 0",
               out_valid, out_rd);
    end
  endtask

  task automatic test_flush();
    out_ready = 0;
    drive(1, 2'b00, 32'h11, 5'd1, 0, 0, 5'd1);
    tick();
    drive(1, 2'b00, 32'h22, 5'd1, 0, 0, 5'd2);
    tick();
    drive(1, 2'b00, 32'h99, 5'd1, 0, 0, 5'd9);
    flush = 1;
    tick();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush_full got v=%b rdy=%b exp 0 1",
               out_valid, in_ready);
    end
    @(negedge clock);
    flush = 0;
    in_valid = 0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop got v=%b rd=%0d exp 0",
               out_valid, out_rd);
    end
    // flush beats an accept into an empty stage
    drive(1, 2'b00, 32'h77, 5'd1, 0, 0, 5'd7);
    flush = 1;
    tick();
    @(negedge clock);
    flush = 0;
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_prio got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_pass_and_reset();
    out_ready = 0;
    drive(1, 2'b11, 32'h1234, 5'd17, 0, 0, 5'd8);
    tick();
    checks++;
    if ({out_valid, out_operand, out_shamt, out_reverse,
         out_invert} !== {1'b1, 32'h1234, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL pass got v=%b op=%h sh=%0d",
               out_valid, out_operand, out_shamt);
    end
    drive(1, 2'b00, 32'h5, 5'd1, 0, 0, 5'd5);
    tick();
    #2;
    reset = 1;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL async_reset got v=%b rdy=%b exp 0 1",
               out_valid, in_ready);
    end
    drive(0, 2'b00, 0, 0, 0, 0, 0);
    reset = 0;
    out_ready = 1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got v=%b exp 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_srl();
    test_sra_neg();
    test_back_to_back();
    test_flush();
    test_pass_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
